// File: rtl/tc_program_fetch8_pkg.sv
// Shared types and sizing helpers for the TC program fetch unit.
package tc_fetch_pkg;

  localparam int unsigned MAX_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  function automatic int unsigned instr_width(input int unsigned n_bytes);
    return 8 * n_bytes;
  endfunction

  // Byte counters index lanes 0..n_bytes-1; keep at least one bit for n_bytes=1.
  function automatic int unsigned cnt_width(input int unsigned n_bytes);
    return (n_bytes <= 1) ? 1 : $clog2(n_bytes);
  endfunction

endpackage

// File: rtl/tc_program_fetch8.sv
// Program fetch initiator: issues byte reads to the TC program ROM, assembles
// INSTR_BYTES bytes into an instruction and offers it over valid/ready.
module tc_program_fetch8
  import tc_fetch_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = 4,
  parameter logic [7:0]  RESET_PC    = 8'h00
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  output logic [7:0]                          mem_addr,
  input  logic [7:0]                          mem_data,
  output logic                                instr_valid,
  input  logic                                instr_ready,
  output logic [instr_width(INSTR_BYTES)-1:0] instr,
  output logic [7:0]                          pc,
  input  logic                                jump_valid,
  input  logic [7:0]                          jump_target
);

  localparam int unsigned IW    = instr_width(INSTR_BYTES);
  localparam int unsigned CNT_W = cnt_width(INSTR_BYTES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(INSTR_BYTES - 1);

  fetch_state_e     state_q;
  logic [7:0]       pc_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] recv_cnt_q;
  logic             rd_pending_q;
  logic             instr_valid_q;
  logic [IW-1:0]    instr_q;
  logic [7:0]       pc_inc_d;

  assign pc_inc_d    = pc_q + 8'(INSTR_BYTES);
  assign mem_addr    = pc_q + 8'(issue_cnt_q);
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;

  // rd_pending_q marks that a read was issued on the previous cycle, so the
  // current mem_data belongs to lane recv_cnt_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      issue_cnt_q   <= '0;
      recv_cnt_q    <= '0;
      rd_pending_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
    end else if (jump_valid) begin
      pc_q          <= jump_target;
      issue_cnt_q   <= '0;
      recv_cnt_q    <= '0;
      rd_pending_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      state_q       <= enable ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_q <= FETCH;
        end

        FETCH: begin
          if (!enable) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
          end else begin
            if (issue_cnt_q != LAST_LANE) issue_cnt_q <= issue_cnt_q + 1'b1;
            rd_pending_q <= 1'b1;
            if (rd_pending_q) begin
              for (int unsigned b = 0; b < INSTR_BYTES; b++) begin
                if (recv_cnt_q == CNT_W'(b)) instr_q[8*b +: 8] <= mem_data;
              end
              if (recv_cnt_q == LAST_LANE) begin
                state_q       <= VALID;
                instr_valid_q <= 1'b1;
                issue_cnt_q   <= '0;
                recv_cnt_q    <= '0;
                rd_pending_q  <= 1'b0;
              end else begin
                recv_cnt_q <= recv_cnt_q + 1'b1;
              end
            end
          end
        end

        VALID: begin
          if (instr_valid_q && instr_ready) begin
            pc_q          <= pc_inc_d;
            instr_valid_q <= 1'b0;
            state_q       <= enable ? FETCH : IDLE;
          end
        end

        default: begin
          state_q       <= IDLE;
          issue_cnt_q   <= '0;
          recv_cnt_q    <= '0;
          rd_pending_q  <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_program_fetch8.sv
// Bench for tc_program_fetch8 with a registered-read program memory model
// (mem[i]=i) and a scoreboard of expected {instr, pc} handshakes.
module tb_tc_program_fetch8;

  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [7:0]    mem_addr;
  logic [7:0]    mem_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [8*NB-1:0] instr;
  logic [7:0]    pc;
  logic          jump_valid;
  logic [7:0]    jump_target;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8*NB+7:0] sb_q[$];
  logic [7:0]      mem[256];

  always #5 clk = ~clk;

  tc_program_fetch8 #(.INSTR_BYTES(NB), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .pc         (pc),
    .jump_valid (jump_valid),
    .jump_target(jump_target)
  );

  // Program memory responder: data for the address sampled at the previous edge.
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Handshake monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      logic [8*NB+7:0] exp_v;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL handshake_unexpected: got instr=%h pc=%h, required no handshake", instr, pc);
      end else begin
        exp_v = sb_q.pop_front();
        if ({instr, pc} !== exp_v) begin
          tests_failed++;
          $display("FAIL handshake_data: got instr=%h pc=%h, required instr=%h pc=%h",
                   instr, pc, exp_v[8*NB+7:8], exp_v[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int exp_cycles);
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!instr_valid && cyc < 50);
    tests_run++;
    if (!instr_valid || cyc != exp_cycles) begin
      tests_failed++;
      $display("FAIL %s_latency: got valid=%b after %0d cycles, required valid=1 after %0d",
               name, instr_valid, cyc, exp_cycles);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    tests_run++;
    if (got !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (instr_valid !== 1'b0 || instr !== '0 || pc !== 8'h00 || mem_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b instr=%h pc=%h addr=%h, required 0/0/00/00",
               instr_valid, instr, pc, mem_addr);
    end
  endtask

  task automatic test_basic();
    sb_q.push_back({32'h03020100, 8'h00});
    sb_q.push_back({32'h07060504, 8'h04});
    enable = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    wait_valid("basic_first", 6);
    wait_valid("basic_second", 6);
    enable = 1'b0;
    tick();
    tests_run++;
    if (instr_valid !== 1'b0 || pc !== 8'h08) begin
      tests_failed++;
      $display("FAIL basic_after: got valid=%b pc=%h, required valid=0 pc=08", instr_valid, pc);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    enable = 1'b1;
    instr_ready = 1'b0;
    wait_valid("bp", 6);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== 32'h0B0A0908 || pc !== 8'h08 || mem_addr !== 8'h08) begin
        tests_failed++;
        $display("FAIL bp_hold: cycle %0d got valid=%b instr=%h pc=%h addr=%h, required 1/0b0a0908/08/08",
                 i, instr_valid, instr, pc, mem_addr);
      end
      tick();
    end
    sb_q.push_back({32'h0B0A0908, 8'h08});
    instr_ready = 1'b1;
    enable = 1'b0;
    tick();
    instr_ready = 1'b0;
    tick();
    check8("bp_next_pc", pc, 8'h0C);
  endtask

  task automatic test_wrap();
    enable = 1'b1;
    jump_valid = 1'b1;
    jump_target = 8'hFE;
    tick();
    jump_valid = 1'b0;
    check8("wrap_pc", pc, 8'hFE);
    wait_valid("wrap", 5);
    sb_q.push_back({32'h0100FFFE, 8'hFE});
    instr_ready = 1'b1;
    enable = 1'b0;
    tick();
    instr_ready = 1'b0;
    check8("wrap_next_pc", pc, 8'h02);
  endtask

  task automatic test_jump_mid_fetch();
    enable = 1'b1;
    instr_ready = 1'b1;
    sb_q.push_back({32'h43424140, 8'h40});
    repeat (4) tick();
    jump_valid = 1'b1;
    jump_target = 8'h40;
    tick();
    jump_valid = 1'b0;
    check8("jmf_pc", pc, 8'h40);
    wait_valid("jmf", 5);
    enable = 1'b0;
    tick();
    instr_ready = 1'b0;
    check8("jmf_next_pc", pc, 8'h44);
  endtask

  task automatic test_jump_handshake();
    enable = 1'b1;
    instr_ready = 1'b0;
    wait_valid("jhs", 6);
    sb_q.push_back({32'h47464544, 8'h44});
    instr_ready = 1'b1;
    jump_valid = 1'b1;
    jump_target = 8'h80;
    tick();
    jump_valid = 1'b0;
    instr_ready = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b0 || pc !== 8'h80) begin
      tests_failed++;
      $display("FAIL jhs_pc: got valid=%b pc=%h, required valid=0 pc=80", instr_valid, pc);
    end
    repeat (2) tick();
    enable = 1'b0;
    tick();
    tests_run++;
    if (instr_valid !== 1'b0 || pc !== 8'h80 || mem_addr !== 8'h80) begin
      tests_failed++;
      $display("FAIL abort_state: got valid=%b pc=%h addr=%h, required 0/80/80",
               instr_valid, pc, mem_addr);
    end
    enable = 1'b1;
    wait_valid("refetch", 6);
    sb_q.push_back({32'h83828180, 8'h80});
    instr_ready = 1'b1;
    enable = 1'b0;
    tick();
    instr_ready = 1'b0;
    check8("refetch_next_pc", pc, 8'h84);
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    instr_ready = 1'b0;
    wait_valid("areset", 6);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || pc !== 8'h00 || instr !== '0 || mem_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b pc=%h instr=%h addr=%h, required 0/00/0/00",
               instr_valid, pc, instr, mem_addr);
    end
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check8("post_reset_pc", pc, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b0;
    enable = 1'b0;
    instr_ready = 1'b0;
    jump_valid = 1'b0;
    jump_target = 8'h00;

    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_jump_mid_fetch();
    test_jump_handshake();
    test_async_reset();

    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
